// File: rtl/ooo_read_responder.sv
// Out-of-order AR/R slave model: holds each 4-bit-ID read for MIN_LAT + (lfsr & LAT_MASK) cycles, then returns lowest expired ID first.
// Response beat is registered (earliest rvalid at accept+L+1); rready backpressure holds the beat while AR accept continues.
module ooo_read_responder #(
  parameter int          DATA_WIDTH      = 8,
  parameter int          MAX_OUTSTANDING = 16,
  parameter int          MIN_LAT         = 1,
  parameter logic [3:0]  LAT_MASK        = 4'hF,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [3:0]            s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                state_q, state_nxt;
  logic [15:0]           pending;
  logic [4:0]            cnt [16];
  logic [DATA_WIDTH-1:0] mem [16];
  logic [7:0]            lfsr;
  logic [4:0]            pend_cnt;
  logic [15:0]           expired;
  logic                  any_exp;
  logic [3:0]            sel;
  logic [4:0]            lat;
  logic                  accept;
  logic                  load;
  logic                  hs;
  logic                  rvalid_q;
  logic [3:0]            rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign s_rvalid_o = rvalid_q;
  assign s_rid_o    = rid_q;
  assign s_rdata_o  = rdata_q;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < 16; i++) pend_cnt = pend_cnt + {4'b0, pending[i]};
  end

  assign s_arready_o = !pending[s_arid_i] && (pend_cnt < 5'(MAX_OUTSTANDING));
  assign accept      = s_arvalid_i && s_arready_o;
  assign lat         = 5'(MIN_LAT) + {1'b0, lfsr[3:0] & LAT_MASK};

  // The beat already on the bus must not be selected a second time.
  always_comb begin
    for (int i = 0; i < 16; i++)
      expired[i] = pending[i] && (cnt[i] == 5'd0) && !(rvalid_q && (rid_q == 4'(i)));
  end

  assign any_exp = |expired;

  always_comb begin
    sel = '0;
    for (int i = 15; i >= 0; i--)
      if (expired[i]) sel = 4'(i);
  end

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    hs        = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_exp) begin
          load      = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (s_rready_i) begin
          hs = 1'b1;
          if (any_exp) load = 1'b1;
          else state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        rvalid_q <= 1'b1;
        rid_q    <= sel;
        rdata_q  <= mem[sel];
      end else if (hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // An accept and a completion never target the same ID at one edge (arready is low while pending).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= '0;
        mem[i] <= DATA_WIDTH'(i * 17);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (accept && (s_arid_i == 4'(i))) begin
          pending[i] <= 1'b1;
          cnt[i]     <= lat;
        end else begin
          if (hs && (rid_q == 4'(i))) pending[i] <= 1'b0;
          if (pending[i] && (cnt[i] != 5'd0)) cnt[i] <= cnt[i] - 5'd1;
        end
        if (hs && (rid_q == 4'(i))) mem[i] <= mem[i] + DATA_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ooo_read_responder.sv
// Bench for ooo_read_responder: directed AR stimulus with expected R beats queued in completion order and
// checked by an independent monitor; a second instance with random latency is checked for range and spread.
module tb_ooo_read_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] arid;
  logic       arvalid;
  logic       arready;
  logic [7:0] rdata;
  logic [3:0] rid;
  logic       rvalid;
  logic       rready;

  logic [3:0] rnd_arid;
  logic       rnd_arvalid;
  logic       rnd_arready;
  logic [7:0] rnd_rdata;
  logic [3:0] rnd_rid;
  logic       rnd_rvalid;
  logic       rnd_rready;

  int n_chk  = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  ooo_read_responder #(
    .DATA_WIDTH(8), .MAX_OUTSTANDING(3), .MIN_LAT(2), .LAT_MASK(4'h0), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arid_i(arid), .s_arvalid_i(arvalid), .s_arready_o(arready),
    .s_rdata_o(rdata), .s_rid_o(rid), .s_rvalid_o(rvalid), .s_rready_i(rready)
  );

  ooo_read_responder u_rnd (
    .clk(clk), .rst_n(rst_n),
    .s_arid_i(rnd_arid), .s_arvalid_i(rnd_arvalid), .s_arready_o(rnd_arready),
    .s_rdata_o(rnd_rdata), .s_rid_o(rnd_rid), .s_rvalid_o(rnd_rvalid), .s_rready_i(rnd_rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [7:0] data, input bit track);
    arid    = id;
    arvalid = 1'b1;
    #1;
    chk("ar_accept", {31'b0, arready}, 32'd1);
    if (track) exp_q.push_back({id, data});
    tick();
    arvalid = 1'b0;
  endtask

  // Scoreboard monitor: every R handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL r_unexpected: got rid=%0h rdata=%0h, expected no beat", rid, rdata);
      end else begin
        chk("r_beat", {20'b0, rid, rdata}, {20'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int d;
    int lat[4];

    rst_n = 1'b0; arid = '0; arvalid = 1'b0; rready = 1'b0;
    rnd_arid = '0; rnd_arvalid = 1'b0; rnd_rready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rid", {28'b0, rid}, 32'd0);
    chk("rst_rdata", {24'b0, rdata}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_arready0", {31'b0, arready}, 32'd1);
    arid = 4'd15;
    #1;
    chk("rst_arready15", {31'b0, arready}, 32'd1);
    tick();

    // Random-latency instance: rvalid must rise 2..17 edges after accept.
    for (int r = 0; r < 4; r++) begin
      rnd_arid    = 4'(r);
      rnd_arvalid = 1'b1;
      #1;
      chk("rnd_arready", {31'b0, rnd_arready}, 32'd1);
      tick();
      rnd_arvalid = 1'b0;
      d = 0;
      while (!rnd_rvalid && d < 40) begin
        tick();
        d++;
      end
      chk("rnd_lat_range", {31'b0, (d >= 2 && d <= 17)}, 32'd1);
      chk("rnd_rid", {28'b0, rnd_rid}, r);
      chk("rnd_rdata", {24'b0, rnd_rdata}, r * 17);
      lat[r] = d;
      tick();
    end
    chk("rnd_spread", {31'b0, (lat[0] != lat[1] || lat[0] != lat[2] || lat[0] != lat[3])}, 32'd1);

    // Basic read: latency 2, rvalid at accept+3, gone at accept+4.
    rready = 1'b1;
    issue(4'd5, 8'h55, 1'b1);
    repeat (2) begin
      tick();
      chk("basic_early", {31'b0, rvalid}, 32'd0);
    end
    tick();
    chk("basic_rvalid", {31'b0, rvalid}, 32'd1);
    chk("basic_beat", {20'b0, rid, rdata}, {20'b0, 4'd5, 8'h55});
    tick();
    chk("basic_drop", {31'b0, rvalid}, 32'd0);

    // Priority: 9 presented and held, then 2 and 7 back to back.
    rready = 1'b0;
    issue(4'd9, 8'h99, 1'b1);
    issue(4'd2, 8'h22, 1'b1);
    issue(4'd7, 8'h77, 1'b1);
    tick();
    chk("prio_first", {27'b0, rvalid, rid}, {27'b0, 1'b1, 4'd9});
    repeat (10) tick();
    chk("prio_held", {19'b0, rvalid, rid, rdata}, {19'b0, 1'b1, 4'd9, 8'h99});
    rready = 1'b1;
    tick();
    chk("prio_b2", {27'b0, rvalid, rid}, {27'b0, 1'b1, 4'd2});
    tick();
    chk("prio_b3", {27'b0, rvalid, rid}, {27'b0, 1'b1, 4'd7});
    tick();
    chk("prio_done", {31'b0, rvalid}, 32'd0);

    // Backpressure: beat stable for 12 cycles while ID 4 is accepted.
    rready = 1'b0;
    issue(4'd1, 8'h11, 1'b1);
    repeat (3) tick();
    for (int k = 0; k < 12; k++) begin
      if (k == 4) issue(4'd4, 8'h44, 1'b1);
      else tick();
      chk("bp_hold", {19'b0, rvalid, rid, rdata}, {19'b0, 1'b1, 4'd1, 8'h11});
    end
    rready = 1'b1;
    tick();
    chk("bp_next", {19'b0, rvalid, rid, rdata}, {19'b0, 1'b1, 4'd4, 8'h44});
    tick();
    chk("bp_done", {31'b0, rvalid}, 32'd0);

    // Duplicate ID stalls until its beat completes; re-read returns incremented data.
    rready = 1'b0;
    issue(4'd3, 8'h33, 1'b1);
    arid    = 4'd3;
    arvalid = 1'b1;
    repeat (5) begin
      tick();
      chk("dup_stall", {31'b0, arready}, 32'd0);
    end
    rready = 1'b1;
    tick();
    chk("dup_release", {31'b0, arready}, 32'd1);
    exp_q.push_back({4'd3, 8'h34});
    tick();
    arvalid = 1'b0;
    repeat (3) tick();
    chk("dup_reread", {19'b0, rvalid, rid, rdata}, {19'b0, 1'b1, 4'd3, 8'h34});
    tick();
    chk("dup_done", {31'b0, rvalid}, 32'd0);

    // Outstanding limit (3): issue 5,2,1; completion order is 5 then lowest ID 1, then 2.
    rready = 1'b0;
    issue(4'd5, 8'h56, 1'b0);
    issue(4'd2, 8'h23, 1'b0);
    issue(4'd1, 8'h12, 1'b0);
    exp_q.push_back({4'd5, 8'h56});
    exp_q.push_back({4'd1, 8'h12});
    exp_q.push_back({4'd2, 8'h23});
    arid    = 4'd6;
    arvalid = 1'b1;
    #1;
    chk("lim_stall", {31'b0, arready}, 32'd0);
    repeat (4) begin
      tick();
      chk("lim_stall", {31'b0, arready}, 32'd0);
    end
    rready = 1'b1;
    tick();
    chk("lim_release", {31'b0, arready}, 32'd1);
    chk("lim_order", {27'b0, rvalid, rid}, {27'b0, 1'b1, 4'd1});
    exp_q.push_back({4'd6, 8'h66});
    tick();
    arvalid = 1'b0;
    repeat (5) tick();
    chk("lim_done", {31'b0, rvalid}, 32'd0);

    // Reset while a beat is presented and three IDs are pending.
    rready = 1'b0;
    issue(4'd7, 8'h78, 1'b0);
    issue(4'd8, 8'h88, 1'b0);
    issue(4'd10, 8'haa, 1'b0);
    tick();
    chk("rst_mid_pre", {27'b0, rvalid, rid}, {27'b0, 1'b1, 4'd7});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_mid_rid", {28'b0, rid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    arid = 4'd7;
    #1;
    chk("rst_mid_arready", {31'b0, arready}, 32'd1);
    tick();
    rready = 1'b1;
    issue(4'd3, 8'h33, 1'b1);
    repeat (2) tick();
    tick();
    chk("rst_mid_read", {19'b0, rvalid, rid, rdata}, {19'b0, 1'b1, 4'd3, 8'h33});
    tick();
    chk("rst_mid_done", {31'b0, rvalid}, 32'd0);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
